// File: rtl/sha2_core.sv
// sha2_core: SHA-224/256 (WORD_W=32) or SHA-384/512 (WORD_W=64) compression engine
// with an internal 16-word message schedule window and multi-block chaining.
`default_nettype none

module sha2_core #(
    parameter int WORD_W = 32
) (
    input  logic                  axi_aclk,
    input  logic                  reset,
    input  logic                  variant,
    input  logic [WORD_W-1:0]     s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [8*WORD_W-1:0]   m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [15:0]           blk_cnt,
    output logic                  err
);

    localparam int c_ROUNDS = (WORD_W == 64) ? 80 : 64;
    localparam int c_BS0_A = (WORD_W == 64) ? 28 : 2;
    localparam int c_BS0_B = (WORD_W == 64) ? 34 : 13;
    localparam int c_BS0_C = (WORD_W == 64) ? 39 : 22;
    localparam int c_BS1_A = (WORD_W == 64) ? 14 : 6;
    localparam int c_BS1_B = (WORD_W == 64) ? 18 : 11;
    localparam int c_BS1_C = (WORD_W == 64) ? 41 : 25;
    localparam int c_SS0_A = (WORD_W == 64) ? 1  : 7;
    localparam int c_SS0_B = (WORD_W == 64) ? 8  : 18;
    localparam int c_SS0_C = (WORD_W == 64) ? 7  : 3;
    localparam int c_SS1_A = (WORD_W == 64) ? 19 : 17;
    localparam int c_SS1_B = (WORD_W == 64) ? 61 : 19;
    localparam int c_SS1_C = (WORD_W == 64) ? 6  : 10;

    // The 32-bit round constants are the upper halves of the 64-bit ones.
    localparam logic [63:0] c_K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // SHA-256 IV = upper halves of the SHA-512 IV; SHA-224 IV = lower halves of the SHA-384 IV.
    localparam logic [63:0] c_IV512 [0:7] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [63:0] c_IV384 [0:7] = '{
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EXPAND = 3'd2,
        S_FINAL  = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    state_t               r_state;
    logic                 r_tready;
    logic                 r_tvalid;
    logic [8*WORD_W-1:0]  r_tdata;
    logic                 r_err;
    logic [15:0]          r_blk_cnt;
    logic [6:0]           r_t;
    logic                 r_last;
    logic [WORD_W-1:0]    r_H  [0:7];
    logic [WORD_W-1:0]    r_wk [0:7];
    logic [WORD_W-1:0]    r_w  [0:15];

    logic [WORD_W-1:0]    w_iv   [0:7];
    logic [WORD_W-1:0]    w_in   [0:7];
    logic [WORD_W-1:0]    w_nxt  [0:7];
    logic [WORD_W-1:0]    w_hsum [0:7];
    logic [WORD_W-1:0]    w_wt, w_k, w_t1, w_t2, w_s0, w_s1;
    logic                 w_acc, w_ferr, w_round;

    assign w_acc   = s_axis_tvalid & r_tready;
    assign w_ferr  = w_acc & s_axis_tlast & (r_t != 7'd15);
    assign w_round = (w_acc & ~w_ferr) | (r_state == S_EXPAND);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_iv[i]   = variant ? c_IV384[i][WORD_W-1:0] : c_IV512[i][63 -: WORD_W];
            // Round 0 runs straight off the IV while still in IDLE.
            w_in[i]   = (r_state == S_IDLE) ? w_iv[i] : r_wk[i];
            w_hsum[i] = r_H[i] + r_wk[i];
        end
        w_s0 = rotr(r_w[1], c_SS0_A) ^ rotr(r_w[1], c_SS0_B) ^ (r_w[1] >> c_SS0_C);
        w_s1 = rotr(r_w[14], c_SS1_A) ^ rotr(r_w[14], c_SS1_B) ^ (r_w[14] >> c_SS1_C);
        w_wt = (r_state == S_EXPAND) ? (w_s1 + r_w[9] + w_s0 + r_w[0]) : s_axis_tdata;
        w_k  = c_K512[r_t][63 -: WORD_W];
        w_t1 = w_in[7]
             + (rotr(w_in[4], c_BS1_A) ^ rotr(w_in[4], c_BS1_B) ^ rotr(w_in[4], c_BS1_C))
             + ((w_in[4] & w_in[5]) ^ (~w_in[4] & w_in[6]))
             + w_k + w_wt;
        w_t2 = (rotr(w_in[0], c_BS0_A) ^ rotr(w_in[0], c_BS0_B) ^ rotr(w_in[0], c_BS0_C))
             + ((w_in[0] & w_in[1]) ^ (w_in[0] & w_in[2]) ^ (w_in[1] & w_in[2]));
        w_nxt[0] = w_t1 + w_t2;
        w_nxt[1] = w_in[0];
        w_nxt[2] = w_in[1];
        w_nxt[3] = w_in[2];
        w_nxt[4] = w_in[3] + w_t1;
        w_nxt[5] = w_in[4];
        w_nxt[6] = w_in[5];
        w_nxt[7] = w_in[6];
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tready  <= 1'b0;
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
            r_err     <= 1'b0;
            r_blk_cnt <= '0;
            r_t       <= '0;
            r_last    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_H[i]  <= w_iv[i];
                r_wk[i] <= w_iv[i];
            end
        end else begin
            r_err <= w_ferr;
            case (r_state)
                S_IDLE: begin
                    r_tready <= 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        r_H[i]  <= w_iv[i];
                        r_wk[i] <= w_iv[i];
                    end
                    if (w_round) begin
                        r_t     <= r_t + 7'd1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_ferr) begin
                        r_state   <= S_IDLE;
                        r_t       <= '0;
                        r_blk_cnt <= '0;
                        for (int i = 0; i < 8; i++) begin
                            r_H[i]  <= w_iv[i];
                            r_wk[i] <= w_iv[i];
                        end
                    end else if (w_round) begin
                        r_t <= r_t + 7'd1;
                        if (r_t == 7'd15) begin
                            r_last   <= s_axis_tlast;
                            r_tready <= 1'b0;
                            r_state  <= S_EXPAND;
                        end
                    end
                end
                S_EXPAND: begin
                    r_t <= r_t + 7'd1;
                    if (r_t == 7'(c_ROUNDS - 1))
                        r_state <= S_FINAL;
                end
                S_FINAL: begin
                    r_t       <= '0;
                    r_blk_cnt <= r_blk_cnt + 16'd1;
                    for (int i = 0; i < 8; i++) begin
                        r_H[i]  <= w_hsum[i];
                        r_wk[i] <= w_hsum[i];
                    end
                    if (r_last) begin
                        for (int i = 0; i < 8; i++)
                            r_tdata[(7-i)*WORD_W +: WORD_W] <= w_hsum[i];
                        r_tvalid <= 1'b1;
                        r_state  <= S_OUTPUT;
                    end else begin
                        r_tready <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end
                S_OUTPUT: begin
                    if (m_axis_tready) begin
                        r_tvalid  <= 1'b0;
                        r_tready  <= 1'b1;
                        r_blk_cnt <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_round) begin
                for (int i = 0; i < 8; i++)
                    r_wk[i] <= w_nxt[i];
                for (int i = 0; i < 15; i++)
                    r_w[i] <= r_w[i+1];
                r_w[15] <= w_wt;
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tvalid;
    assign blk_cnt       = r_blk_cnt;
    assign err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sha2_core.sv
// tb_sha2_core: directed known-answer checks for sha2_core at WORD_W=32 and WORD_W=64.
`default_nettype none

module tb_sha2_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         var32, sv32, sl32, sr32, mv32, ml32, mr32, er32;
    logic [31:0]  sd32;
    logic [255:0] md32;
    logic [15:0]  bc32;
    logic         var64, sv64, sl64, sr64, mv64, ml64, mr64, er64;
    logic [63:0]  sd64;
    logic [511:0] md64;
    logic [15:0]  bc64;

    sha2_core #(.WORD_W(32)) u_dut32 (
        .axi_aclk(clk), .reset(rst), .variant(var32),
        .s_axis_tdata(sd32), .s_axis_tvalid(sv32), .s_axis_tready(sr32), .s_axis_tlast(sl32),
        .m_axis_tdata(md32), .m_axis_tvalid(mv32), .m_axis_tready(mr32), .m_axis_tlast(ml32),
        .blk_cnt(bc32), .err(er32)
    );

    sha2_core #(.WORD_W(64)) u_dut64 (
        .axi_aclk(clk), .reset(rst), .variant(var64),
        .s_axis_tdata(sd64), .s_axis_tvalid(sv64), .s_axis_tready(sr64), .s_axis_tlast(sl64),
        .m_axis_tdata(md64), .m_axis_tvalid(mv64), .m_axis_tready(mr64), .m_axis_tlast(ml64),
        .blk_cnt(bc64), .err(er64)
    );

    localparam logic [255:0] c_D256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [223:0] c_D224 =
        224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7;
    localparam logic [255:0] c_D2B =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] c_D512 =
        512'hddaf35a193617aba_cc417349ae204131_12e6fa4e89a97ea2_0a9eeee64b55d39a_2192992a274fc1a8_36ba3c23a3feebbd_454d4423643ce80e_2a9ac94fa54ca49f;
    localparam logic [31:0] c_TWO [0:13] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
        32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
        32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071
    };

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      cyc = 0;
    longint      c0 = 0;
    logic [63:0] msg [0:15];
    int          seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called and returns on a negedge; the transfer happens on the posedge in between.
    task automatic put(input bit w64, input logic [63:0] d, input bit last, input bit gap);
        int n = 0;
        if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
        if (w64) begin sd64 = d; sl64 = last; sv64 = 1'b1; end
        else     begin sd32 = d[31:0]; sl32 = last; sv32 = 1'b1; end
        while (!(w64 ? sr64 : sr32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("put_timeout", 512'(n), 512'd0);
        @(negedge clk);
        sv32 = 1'b0; sv64 = 1'b0; sl32 = 1'b0; sl64 = 1'b0;
    endtask

    task automatic send_blk(input bit w64, input bit last, input bit gap);
        for (int i = 0; i < 16; i++) begin
            put(w64, msg[i], last && (i == 15), gap);
            if (i == 0) c0 = cyc;
        end
    endtask

    task automatic wait_dig(input bit w64, input string tag);
        int n = 0;
        while (!(w64 ? mv64 : mv32) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check(tag, 512'(n), 512'd0);
    endtask

    task automatic load_abc(input bit w64);
        for (int i = 0; i < 16; i++) msg[i] = '0;
        msg[0]  = w64 ? 64'h6162638000000000 : 64'h0000000061626380;
        msg[15] = 64'h18;
    endtask

    initial begin
        rst = 1'b1;
        var32 = 0; sv32 = 0; sl32 = 0; sd32 = '0; mr32 = 0;
        var64 = 0; sv64 = 0; sl64 = 0; sd64 = '0; mr64 = 0;
        @(negedge clk);
        check("rst_tready", sr32, 0);
        check("rst_outs", {mv32, ml32, er32, bc32, md32}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_rst", sr32, 1);

        // SHA-256 "abc", digest sink always ready
        mr32 = 1'b1;
        load_abc(0);
        send_blk(0, 1, 0);
        check("tready_low_in_expand", sr32, 0);
        wait_dig(0, "d256_timeout");
        check("lat256", 512'(cyc - c0), 512'd64);
        check("d256", md32, c_D256);
        check("blk256", bc32, 1);
        check("tlast256", ml32, 1);
        @(negedge clk);
        check("idle_after_out", {mv32, sr32}, 2'b01);

        // SHA-224 "abc"
        var32 = 1'b1; mr32 = 1'b0;
        send_blk(0, 1, 0);
        var32 = 1'b0;
        wait_dig(0, "d224_timeout");
        check("d224", md32[255:32], c_D224);
        mr32 = 1'b1;
        @(negedge clk);

        // Two-block message with input gaps, variant toggled mid-message, sink stalled
        mr32 = 1'b0;
        for (int i = 0; i < 14; i++) msg[i] = 64'(c_TWO[i]);
        msg[14] = 64'h80000000; msg[15] = '0;
        send_blk(0, 0, 1);
        var32 = 1'b1;
        seen = 0;
        while (!sr32 && seen < 200) begin @(negedge clk); seen++; end
        check("blk_mid", bc32, 1);
        for (int i = 0; i < 16; i++) msg[i] = '0;
        msg[15] = 64'h1c0;
        send_blk(0, 1, 1);
        wait_dig(0, "d2b_timeout");
        check("d2b", md32, c_D2B);
        check("blk2b", bc32, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("d2b_stall", {mv32, md32}, {1'b1, c_D2B});
        end
        mr32 = 1'b1;
        var32 = 1'b0;
        @(negedge clk);
        check("d2b_release", mv32, 0);

        // Framing error: tlast on word 7
        load_abc(0);
        for (int i = 0; i < 8; i++) put(0, msg[i], i == 7, 0);
        check("ferr_pulse", {er32, sr32}, 2'b11);
        @(negedge clk);
        check("ferr_one_cycle", er32, 0);
        seen = 0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (mv32 || er32) seen++;
        end
        check("ferr_no_digest", 512'(seen), 512'd0);
        send_blk(0, 1, 0);
        wait_dig(0, "d_after_ferr_timeout");
        check("d_after_ferr", md32, c_D256);
        check("blk_after_ferr", bc32, 1);
        @(negedge clk);

        // Reset during EXPAND
        send_blk(0, 1, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", {sr32, mv32, ml32, er32, bc32, md32}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tready", sr32, 1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (mv32 || er32) seen++;
        end
        check("midrst_no_digest", 512'(seen), 512'd0);
        send_blk(0, 1, 0);
        wait_dig(0, "d_after_rst_timeout");
        check("d_after_rst", md32, c_D256);
        @(negedge clk);

        // SHA-512 "abc"
        mr64 = 1'b1;
        load_abc(1);
        send_blk(1, 1, 0);
        wait_dig(1, "d512_timeout");
        check("lat512", 512'(cyc - c0), 512'd80);
        check("d512", md64, c_D512);
        check("blk512", bc64, 1);
        @(negedge clk);
        check("idle512", {mv64, sr64}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
